// File: rtl/conv_window_ctrl_pkg.sv
// Shared definitions for the convolver window controller.
// The 2-bit state encoding is the one used by the datapath and line buffer.
package conv_window_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/conv_window_ctrl_wrap_counter.sv
// Modulo counter that steps on i_inc and returns to zero after MODULUS-1.
// o_wrap flags the step that returns it to zero; i_clr has priority over i_inc.
module wrap_counter
    import conv_window_ctrl_pkg::*;
#(
    parameter int MODULUS = 28,
    parameter int WIDTH   = 5
)(
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_count;

    assign o_wrap  = i_inc && (r_count == WIDTH'(MODULUS - 1));
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= o_wrap ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// Window-valid controller: tracks pixels streamed into the line buffers and flags
// stride-aligned positions where a full KERNEL_SIZE x KERNEL_SIZE window is available.
module conv_window_ctrl
    import conv_window_ctrl_pkg::*;
#(
    parameter int IMAGE_W     = 28,
    parameter int IMAGE_H     = 28,
    parameter int KERNEL_SIZE = 5,
    parameter int STRIDE      = 1,
    parameter int CNT_W       = 5
)(
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             pix_valid,
    output logic             busy,
    output logic             enable,
    output logic [CNT_W-1:0] out_col,
    output logic [CNT_W-1:0] out_row,
    output logic             frame_done,
    output logic             err_start
);

    localparam logic [CNT_W-1:0] WIN_FIRST     = CNT_W'(KERNEL_SIZE - 1);
    localparam logic [CNT_W-1:0] FILL_LAST_ROW = CNT_W'(KERNEL_SIZE - 2);
    localparam state_t           FIRST_STATE   = (KERNEL_SIZE == 1) ? ST_RUN : ST_FILL;

    state_t           r_state;
    state_t           w_stateNext;
    logic             r_enable;
    logic             r_frameDone;
    logic             r_errStart;
    logic [CNT_W-1:0] r_outCol;
    logic [CNT_W-1:0] r_outRow;
    logic [CNT_W-1:0] r_colIdx;
    logic [CNT_W-1:0] r_rowIdx;

    logic             w_accept;
    logic             w_startOk;
    logic             w_hit;
    logic             w_lastPix;
    logic             w_colInWin;
    logic             w_rowInWin;
    logic [CNT_W-1:0] w_inCol;
    logic [CNT_W-1:0] w_inRow;
    logic [CNT_W-1:0] w_colPh;
    logic [CNT_W-1:0] w_rowPh;
    logic             w_colWrap;
    logic             w_rowWrap;
    logic             w_colPhWrap;
    logic             w_rowPhWrap;

    assign w_accept   = pix_valid && (r_state != ST_IDLE);
    assign w_startOk  = start && (r_state == ST_IDLE);
    assign w_colInWin = (w_inCol >= WIN_FIRST);
    assign w_rowInWin = (w_inRow >= WIN_FIRST);
    assign w_lastPix  = w_colWrap && w_rowWrap;
    assign w_hit      = w_accept && w_colInWin && w_rowInWin && (w_colPh == '0) && (w_rowPh == '0);

    wrap_counter #(.MODULUS(IMAGE_W), .WIDTH(CNT_W)) u_inCol (
        .clk(clk), .rstn(rstn), .i_inc(w_accept), .i_clr(w_startOk),
        .o_count(w_inCol), .o_wrap(w_colWrap)
    );

    wrap_counter #(.MODULUS(IMAGE_H), .WIDTH(CNT_W)) u_inRow (
        .clk(clk), .rstn(rstn), .i_inc(w_colWrap), .i_clr(w_startOk),
        .o_count(w_inRow), .o_wrap(w_rowWrap)
    );

    // Phase counters only run once the window edge is reached, so phase 0 marks an aligned position
    wrap_counter #(.MODULUS(STRIDE), .WIDTH(CNT_W)) u_colPh (
        .clk(clk), .rstn(rstn), .i_inc(w_accept && w_colInWin), .i_clr(w_startOk || w_colWrap),
        .o_count(w_colPh), .o_wrap(w_colPhWrap)
    );

    wrap_counter #(.MODULUS(STRIDE), .WIDTH(CNT_W)) u_rowPh (
        .clk(clk), .rstn(rstn), .i_inc(w_colWrap && w_rowInWin), .i_clr(w_startOk || w_lastPix),
        .o_count(w_rowPh), .o_wrap(w_rowPhWrap)
    );

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: if (start) w_stateNext = FIRST_STATE;
            ST_FILL: if (w_colWrap && (w_inRow == FILL_LAST_ROW)) w_stateNext = ST_RUN;
            ST_RUN:  if (w_lastPix) w_stateNext = ST_IDLE;
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_enable    <= 1'b0;
            r_frameDone <= 1'b0;
            r_errStart  <= 1'b0;
            r_outCol    <= '0;
            r_outRow    <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_enable    <= w_hit;
            r_frameDone <= w_lastPix;
            r_errStart  <= start && (r_state != ST_IDLE);
            if (w_hit) begin
                r_outCol <= r_colIdx;
                r_outRow <= r_rowIdx;
            end
        end
    end

    // Output indices advance each time a phase counter completes a stride step
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_colIdx <= '0;
            r_rowIdx <= '0;
        end else begin
            if (w_startOk || w_colWrap) begin
                r_colIdx <= '0;
            end else if (w_colPhWrap) begin
                r_colIdx <= r_colIdx + 1'b1;
            end
            if (w_startOk || w_lastPix) begin
                r_rowIdx <= '0;
            end else if (w_rowPhWrap) begin
                r_rowIdx <= r_rowIdx + 1'b1;
            end
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign enable     = r_enable;
    assign out_col    = r_outCol;
    assign out_row    = r_outRow;
    assign frame_done = r_frameDone;
    assign err_start  = r_errStart;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl: a stride-2 8x8 table test plus
// default-size frames checked cycle by cycle against a pixel-index reference model.
module tb_conv_window_ctrl;

    localparam int TW = 28;
    localparam int TH = 28;
    localparam int TK = 5;
    localparam int TS = 1;
    localparam int PIXELS = TW * TH;
    localparam int OUT_TOTAL = ((TW - TK) / TS + 1) * ((TH - TK) / TS + 1);
    localparam int BUDGET = PIXELS * 8 + 100;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       pix_valid;
    logic       busy;
    logic       enable;
    logic [4:0] out_col;
    logic [4:0] out_row;
    logic       frame_done;
    logic       err_start;

    logic       sStart;
    logic       sPv;
    logic       sBusy;
    logic       sEnable;
    logic [2:0] sOutCol;
    logic [2:0] sOutRow;
    logic       sDone;
    logic       sErr;

    int checks = 0;
    int errors = 0;

    bit mdlBusy = 1'b0;
    int mdlPix  = 0;
    int mdlCol  = 0;
    int mdlRow  = 0;
    int enCount = 0;
    int doneCnt = 0;
    int errCnt  = 0;
    int firstEnPix = -1;

    typedef struct {
        int pix;
        bit en;
        int col;
        int row;
    } vec_t;

    vec_t tbl[14];
    bit   obsEn[64];
    int   obsCol[64];
    int   obsRow[64];

    always #5 clk = ~clk;

    conv_window_ctrl dut (
        .clk(clk), .rstn(rstn), .start(start), .pix_valid(pix_valid),
        .busy(busy), .enable(enable), .out_col(out_col), .out_row(out_row),
        .frame_done(frame_done), .err_start(err_start)
    );

    conv_window_ctrl #(.IMAGE_W(8), .IMAGE_H(8), .KERNEL_SIZE(3), .STRIDE(2), .CNT_W(3)) dutSmall (
        .clk(clk), .rstn(rstn), .start(sStart), .pix_valid(sPv),
        .busy(sBusy), .enable(sEnable), .out_col(sOutCol), .out_row(sOutRow),
        .frame_done(sDone), .err_start(sErr)
    );

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit isHit(input int p, output int c, output int r);
        int x;
        int y;
        x = p % TW;
        y = p / TW;
        c = 0;
        r = 0;
        if (x < TK - 1 || y < TK - 1) return 1'b0;
        if (((x - (TK - 1)) % TS) != 0 || ((y - (TK - 1)) % TS) != 0) return 1'b0;
        c = (x - (TK - 1)) / TS;
        r = (y - (TK - 1)) / TS;
        return 1'b1;
    endfunction

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input logic st, input logic pv);
        bit expEn;
        bit expDone;
        bit expErr;
        int c;
        int r;
        logic [13:0] expVec;
        logic [13:0] actVec;
        expEn   = 1'b0;
        expDone = 1'b0;
        expErr  = st && mdlBusy;
        if (mdlBusy && pv) begin
            if (isHit(mdlPix, c, r)) begin
                expEn  = 1'b1;
                mdlCol = c;
                mdlRow = r;
            end
            if (mdlPix == PIXELS - 1) begin
                expDone = 1'b1;
                mdlBusy = 1'b0;
            end
            mdlPix++;
        end else if (!mdlBusy && st) begin
            mdlBusy = 1'b1;
            mdlPix  = 0;
        end
        expVec = {mdlBusy, expEn, expDone, expErr, 5'(mdlCol), 5'(mdlRow)};
        actVec = {busy, enable, frame_done, err_start, out_col, out_row};
        checks++;
        if (actVec !== expVec) begin
            errors++;
            $display("[TB] FAIL cycle pix=%0d busy/en/done/err/col/row: got %b %b %b %b %0d %0d, expected %b %b %b %b %0d %0d",
                     mdlPix, busy, enable, frame_done, err_start, out_col, out_row,
                     mdlBusy, expEn, expDone, expErr, mdlCol, mdlRow);
        end
        if (enable === 1'b1) begin
            enCount++;
            if (firstEnPix < 0) firstEnPix = mdlPix;
        end
        if (frame_done === 1'b1) doneCnt++;
        if (err_start === 1'b1) errCnt++;
    endtask

    task automatic applyStimulus(input logic st, input logic pv);
        start     = st;
        pix_valid = pv;
        @(posedge clk);
        #1;
        checkOutput(st, pv);
    endtask

    task automatic doAbort();
        rstn = 1'b0;
        start = 1'b0;
        pix_valid = 1'b0;
        #1;
        checkVal("abort busy", int'(busy), 0);
        checkVal("abort enable", int'(enable), 0);
        checkVal("abort out_col", int'(out_col), 0);
        checkVal("abort out_row", int'(out_row), 0);
        mdlBusy = 1'b0;
        mdlCol  = 0;
        mdlRow  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic streamFrame(input int pct, input int errAt, input int abortAt);
        int  cyc;
        bit  errSent;
        logic pv;
        logic st;
        cyc = 0;
        errSent = 1'b0;
        applyStimulus(1'b1, 1'b0);
        while (mdlBusy && cyc < BUDGET) begin
            if (mdlPix == abortAt) begin
                doAbort();
                return;
            end
            pv = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
            st = 1'b0;
            if (mdlPix == errAt && pv && !errSent) begin
                st = 1'b1;
                errSent = 1'b1;
            end
            applyStimulus(st, pv);
            cyc++;
        end
        if (mdlBusy) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame timeout: got %0d pixels, expected %0d", mdlPix, PIXELS);
            mdlBusy = 1'b0;
        end
    endtask

    task automatic clearCounts();
        enCount = 0;
        doneCnt = 0;
        errCnt = 0;
        firstEnPix = -1;
    endtask

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        pix_valid = 1'b0;
        sStart = 1'b0;
        sPv = 1'b0;

        tbl[0]  = '{18, 1'b1, 0, 0};
        tbl[1]  = '{20, 1'b1, 1, 0};
        tbl[2]  = '{22, 1'b1, 2, 0};
        tbl[3]  = '{34, 1'b1, 0, 1};
        tbl[4]  = '{36, 1'b1, 1, 1};
        tbl[5]  = '{38, 1'b1, 2, 1};
        tbl[6]  = '{50, 1'b1, 0, 2};
        tbl[7]  = '{52, 1'b1, 1, 2};
        tbl[8]  = '{54, 1'b1, 2, 2};
        tbl[9]  = '{17, 1'b0, 0, 0};
        tbl[10] = '{19, 1'b0, 0, 0};
        tbl[11] = '{23, 1'b0, 0, 0};
        tbl[12] = '{58, 1'b0, 0, 0};
        tbl[13] = '{63, 1'b0, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        checkVal("reset state", int'({busy, enable, frame_done, err_start, out_col, out_row}), 0);
        checkVal("reset state small", int'({sBusy, sEnable, sDone, sErr, sOutCol, sOutRow}), 0);
        @(negedge clk);
        rstn = 1'b1;

        // 8x8, K=3, stride 2
        begin
            int smallEn;
            int smallDone;
            smallEn = 0;
            smallDone = 0;
            sStart = 1'b1;
            @(posedge clk);
            #1;
            sStart = 1'b0;
            checkVal("small busy after start", int'(sBusy), 1);
            for (int p = 0; p < 64; p++) begin
                sPv = 1'b1;
                @(posedge clk);
                #1;
                obsEn[p]  = sEnable;
                obsCol[p] = int'(sOutCol);
                obsRow[p] = int'(sOutRow);
                if (sEnable) smallEn++;
                if (sDone) smallDone++;
                if (p == 63) checkVal("small frame_done after last", int'(sDone), 1);
            end
            sPv = 1'b0;
            checkVal("small busy after frame", int'(sBusy), 0);
            for (int i = 0; i < 14; i++) begin
                checkVal($sformatf("small enable pix %0d", tbl[i].pix), int'(obsEn[tbl[i].pix]), int'(tbl[i].en));
                if (tbl[i].en) begin
                    checkVal($sformatf("small out_col pix %0d", tbl[i].pix), obsCol[tbl[i].pix], tbl[i].col);
                    checkVal($sformatf("small out_row pix %0d", tbl[i].pix), obsRow[tbl[i].pix], tbl[i].row);
                end
            end
            checkVal("small enable total", smallEn, 9);
            checkVal("small done total", smallDone, 1);
        end

        $display("[TB] continuous frame");
        clearCounts();
        streamFrame(100, -1, -1);
        checkVal("t1 enable total", enCount, OUT_TOTAL);
        checkVal("t1 first enable pixel", firstEnPix, 117);
        checkVal("t1 done count", doneCnt, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);

        $display("[TB] random pix_valid frame");
        clearCounts();
        streamFrame(50, -1, -1);
        checkVal("t3 enable total", enCount, OUT_TOTAL);
        checkVal("t3 done count", doneCnt, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);

        $display("[TB] start while busy");
        clearCounts();
        streamFrame(100, 200, -1);
        checkVal("t4 err count", errCnt, 1);
        checkVal("t4 enable total", enCount, OUT_TOTAL);
        checkVal("t4 done count", doneCnt, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);

        $display("[TB] reset mid-frame");
        clearCounts();
        streamFrame(100, -1, 300);
        checkVal("t5 no done after abort", doneCnt, 0);
        clearCounts();
        streamFrame(70, -1, -1);
        checkVal("t5 enable total after restart", enCount, OUT_TOTAL);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0);

        $display("[TB] back-to-back frames");
        clearCounts();
        streamFrame(100, -1, -1);
        streamFrame(100, -1, -1);
        checkVal("t6 enable total", enCount, 2 * OUT_TOTAL);
        checkVal("t6 err count", errCnt, 0);
        checkVal("t6 done count", doneCnt, 2);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0);

        $display("[TB] start with last pixel");
        clearCounts();
        streamFrame(100, PIXELS - 1, -1);
        checkVal("t7 err count", errCnt, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        checkVal("t7 idle after frame", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
